// File: rtl/if_id_skid_if.sv
// IF/ID handshake bundle: fetch-side valid/ready/data, decode-side valid/ready/data, and flush.
interface if_id_skid_if #(
    parameter int INST_W = 32,
    parameter int ADDR_W = 32
);
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [INST_W-1:0] inst_i;
    logic [ADDR_W-1:0] inst_addr_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_addr_o;

    modport slave (
        input  flush_i, in_valid_i, inst_i, inst_addr_i, out_ready_i,
        output in_ready_o, out_valid_o, inst_o, inst_addr_o
    );

    modport master (
        output flush_i, in_valid_i, inst_i, inst_addr_i, out_ready_i,
        input  in_ready_o, out_valid_o, inst_o, inst_addr_o
    );
endinterface

// File: rtl/if_id_skid.sv
// IF/ID register with 2-entry skid buffer, registered in_ready_o, and flush.
// IF_ID_PERF_EN adds saturating stall/flush counters (stall_cnt_o, flush_cnt_o).
module if_id_skid #(
    parameter int                INST_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h00000013)
) (
    input  logic        clk,
    input  logic        rst,
    if_id_skid_if.slave bus
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    localparam entry_t CLEAR_ENT = '{inst: NOP_INST, addr: '0};

    state_t state_q, state_d;
    entry_t main_q, skid_q, in_ent;
    logic   load_main, main_from_skid, load_skid;
    logic   in_fire, out_fire;

    assign in_ent   = '{inst: bus.inst_i, addr: bus.inst_addr_i};
    assign in_fire  = bus.in_valid_i & bus.in_ready_o;
    assign out_fire = bus.out_valid_o & bus.out_ready_i;

    // Handshake outputs come straight from the state register.
    assign bus.out_valid_o = (state_q != EMPTY);
    assign bus.in_ready_o  = (state_q != TWO);
    assign bus.inst_o      = bus.out_valid_o ? main_q.inst : NOP_INST;
    assign bus.inst_addr_o = bus.out_valid_o ? main_q.addr : '0;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            EMPTY: if (in_fire) begin
                state_d   = ONE;
                load_main = 1'b1;
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    state_d   = TWO;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: if (out_fire) begin
                state_d        = ONE;
                load_main      = 1'b1;
                main_from_skid = 1'b1;
            end
            default: state_d = EMPTY;
        endcase
        // A fetch accepted alongside a flush is dropped, not stored.
        if (bus.flush_i) begin
            state_d   = EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= CLEAR_ENT;
            skid_q  <= CLEAR_ENT;
        end else begin
            state_q <= state_d;
            if (load_main) main_q <= main_from_skid ? skid_q : in_ent;
            if (load_skid) skid_q <= in_ent;
        end
    end

`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (bus.out_valid_o && !bus.out_ready_i && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (bus.flush_i && flush_cnt_q != 32'hFFFF_FFFF)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif
endmodule
